// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep and compare for a combinational block
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   f_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          fail_count,
    output logic [N_IN-1:0]        first_fail_idx
);

    localparam int NT = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NT-1:0]   exp_q;
    logic [3:0]      settle_cnt;
    logic            sample_now;
    logic            last_vec;
    logic            mismatch;
    logic [N_IN:0]   fail_count_nxt;

    // The vector has been held long enough; this edge records its result.
    assign sample_now     = (state == RUN) && (settle_cnt == SETTLE_LAST);
    assign last_vec       = (vec_out == LAST_VEC);
    assign mismatch       = (f_in != exp_q[vec_out]);
    assign fail_count_nxt = fail_count + {{N_IN{1'b0}}, mismatch};

    // State register; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (sample_now && last_vec) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector stepping, sampling, comparison and result latching.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out        <= '0;
            settle_cnt     <= '0;
            exp_q          <= '0;
            table_out      <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vec_out    <= '0;
                    settle_cnt <= '0;
                    if (start) begin
                        exp_q          <= expected;
                        table_out      <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_now) begin
                        table_out[vec_out] <= f_in;
                        if (mismatch) begin
                            fail_count <= fail_count_nxt;
                            if (fail_count == '0) begin
                                first_fail_idx <= vec_out;
                            end
                        end
                        if (last_vec) begin
                            // Uses the count including this final sample.
                            pass <= (fail_count_nxt == '0);
                        end else begin
                            vec_out    <= vec_out + 1'b1;
                            settle_cnt <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                FIN: begin
                    vec_out    <= '0;
                    settle_cnt <= '0;
                end
                default: begin
                    vec_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic [3:0]  vec_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail_idx;

    logic        start_b;
    logic [7:0]  expected_b;
    logic        f_in_b;
    logic [2:0]  vec_b;
    logic        busy_b;
    logic        done_b;
    logic        pass_b;
    logic [7:0]  table_b;
    logic [3:0]  fail_b;
    logic [2:0]  first_b;

    logic [15:0] mask;
    logic [7:0]  mask_b;
    logic        tie_one;

    assign f_in   = tie_one ? 1'b1 : mask[vec_out];
    assign f_in_b = mask_b[vec_b];

    truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .f_in(f_in),
        .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
        .table_out(table_out), .fail_count(fail_count), .first_fail_idx(first_fail_idx)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(expected_b), .f_in(f_in_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .table_out(table_b), .fail_count(fail_b), .first_fail_idx(first_b)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start at the edge ending cycle T, then run until done; cyc = cycles after T.
    task automatic sweep_a(input logic [15:0] exp_v, input bit poke, output int cyc);
        expected = exp_v;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        chk("a_vec_t1", vec_out, 0);
        chk("a_busy_t1", busy, 1);
        while (!done && cyc < 100) begin
            if (poke && cyc == 10) begin
                start    = 1'b1;
                expected = ~exp_v;
            end
            tick();
            start = 1'b0;
            cyc++;
            if (cyc == 3)  chk("a_vec_t3", vec_out, 1);
            if (cyc == 32) chk("a_vec_t32", vec_out, 15);
        end
    endtask

    int cyc;
    int done_seen;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_b    = 1'b0;
        expected   = 16'h0;
        expected_b = 8'h96;
        mask       = 16'hA5C3;
        mask_b     = 8'h96;
        tie_one    = 1'b0;
        tick();
        tick();
        chk("rst_vec", vec_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_table", table_out, 0);
        chk("rst_fail", fail_count, 0);
        chk("rst_first", first_fail_idx, 0);
        chk("rst_b_table", table_b, 0);
        rst = 1'b0;
        tick();

        // Matching table.
        sweep_a(16'hA5C3, 1'b0, cyc);
        chk("s1_done_cyc", cyc, 33);
        chk("s1_pass", pass, 1);
        chk("s1_table", table_out, 16'hA5C3);
        chk("s1_fail", fail_count, 0);
        chk("s1_first", first_fail_idx, 0);
        tick();
        chk("s1_done_pulse", done, 0);
        chk("s1_idle_busy", busy, 0);
        chk("s1_idle_vec", vec_out, 0);
        chk("s1_hold_pass", pass, 1);

        // Two mismatches at minterms 3 and 9.
        sweep_a(16'hA5C3 ^ 16'h0208, 1'b0, cyc);
        chk("s2_done_cyc", cyc, 33);
        chk("s2_pass", pass, 0);
        chk("s2_fail", fail_count, 2);
        chk("s2_first", first_fail_idx, 3);
        chk("s2_table", table_out, 16'hA5C3);
        tick();

        // Every minterm mismatches; count reaches 2^N_IN.
        tie_one = 1'b1;
        sweep_a(16'h0000, 1'b0, cyc);
        chk("s3_pass", pass, 0);
        chk("s3_fail", fail_count, 16);
        chk("s3_first", first_fail_idx, 0);
        chk("s3_table", table_out, 16'hFFFF);
        tie_one = 1'b0;
        tick();

        // Start and expected changes mid-sweep are ignored.
        sweep_a(16'hA5C3, 1'b1, cyc);
        chk("s4_done_cyc", cyc, 33);
        chk("s4_pass", pass, 1);
        chk("s4_fail", fail_count, 0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("s4_no_second_done", done_seen, 0);
        chk("s4_idle_busy", busy, 0);
        expected = 16'hA5C3;

        // Reset mid-sweep aborts without done.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        chk("s5_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_vec", vec_out, 0);
        chk("s5_table", table_out, 0);
        chk("s5_done", done, 0);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("s5_no_done", done_seen, 0);
        sweep_a(16'hA5C3, 1'b0, cyc);
        chk("s5_fresh_cyc", cyc, 33);
        chk("s5_fresh_pass", pass, 1);
        tick();

        // Small instance: N_IN=3, SETTLE=1.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 1;
        chk("b_vec_t1", vec_b, 0);
        while (!done_b && cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 4) chk("b_vec_t4", vec_b, 3);
        end
        chk("b_done_cyc", cyc, 9);
        chk("b_pass", pass_b, 1);
        chk("b_table", table_b, 8'h96);
        chk("b_fail", fail_b, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives a combinational 4-input function block through all 2^N_IN input combinations in minterm order.
- Samples the block's single output for each combination and assembles the measured truth table.
- Compares the table against an expected minterm mask and reports pass/fail, mismatch count and first failing minterm.
- Sits beside the combinational problem modules: it sequences their inputs in hardware, replacing a hand-written vector list.

Parameters:
- N_IN, 4, number of function inputs; the table holds 2^N_IN entries.
- SETTLE, 2, cycles each input vector is held before its output is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; honoured only in IDLE
- expected  input  2^N_IN  expected truth table; bit k = f for minterm k; latched on accepted start
- f_in  input  1  output of the function block under control
- vec_out  output  N_IN  input vector to the function block; MSB drives a, LSB drives d
- busy  output  1  high while a sweep is running
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  1 when the measured table equals the expected table; valid from done until the next accepted start
- table_out  output  2^N_IN  measured truth table; bit k = f_in sampled for minterm k
- fail_count  output  N_IN+1  number of mismatching minterms (0..2^N_IN)
- first_fail_idx  output  N_IN  lowest mismatching minterm; meaningful only when pass=0, otherwise 0

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE and every output is 0: vec_out, busy, done, pass, table_out, fail_count, first_fail_idx. The expected latch and the settle counter are also cleared. Reset wins over every other input in the same cycle.
- States:
  - IDLE: vec_out=0, busy=0.
  - RUN: busy=1.
  - FIN: one cycle, done=1, busy=0.
- Transitions:
  - IDLE->RUN: start=1 at an edge. That edge latches expected, clears table_out, fail_count, first_fail_idx and pass, and sets vec_out=0 and settle counter=0.
  - RUN: each vector is held exactly SETTLE cycles. At the edge ending the SETTLE-th cycle:
    - table_out[vec] <= f_in.
    - If f_in != expected_latched[vec]: fail_count increments; if it was the first mismatch, first_fail_idx <= vec.
    - If vec = 2^N_IN-1, go to FIN; otherwise vec_out increments and the settle counter clears.
  - FIN->IDLE unconditionally. In FIN, pass = (fail_count==0), computed from the final count including the last sample. vec_out returns to 0 in IDLE.
- Timing: start sampled at the edge ending cycle T.
  - vec_out=k during cycles T+1+k*SETTLE .. T+(k+1)*SETTLE.
  - done=1 in cycle T+1+2^N_IN*SETTLE; for the defaults this is T+33.
- start while busy or in FIN is ignored. It is not queued, and expected is not re-latched.
- start held high continuously: a new sweep begins at the edge after FIN, i.e. from IDLE.
- Results (table_out, pass, fail_count, first_fail_idx) hold their values in IDLE until the next accepted start or reset.
- Changes to the expected input during RUN have no effect.
- vec_out never wraps inside a sweep: the last vector is followed by FIN, not by vector 0 in RUN.
- fail_count saturates naturally at 2^N_IN, which requires N_IN+1 bits; no overflow is possible.
- rst asserted mid-sweep aborts at that edge: all outputs return to reset values and no done pulse is produced.

Test Plan:
- Bench drives f_in from a model of mask 16'hA5C3 indexed by vec_out; expected=16'hA5C3; start pulse at cycle T -> vec_out steps 0..15, two cycles each; done at T+33; pass=1; table_out=16'hA5C3; fail_count=0; first_fail_idx=0.
- Same model, expected=16'hA5C3 ^ 16'h0208 -> done at T+33; pass=0; fail_count=2; first_fail_idx=3; table_out=16'hA5C3.
- f_in tied 1, expected=16'h0000 -> pass=0; fail_count=16; first_fail_idx=0; table_out=16'hFFFF.
- start pulsed again at T+10 and expected changed during the sweep -> the second start is ignored; a single done at T+33; results reflect the original expected value.
- rst asserted at T+12 -> next cycle busy=0, vec_out=0, table_out=0, no done. A fresh start afterwards completes normally with pass=1.
- SETTLE=1, N_IN=3, model mask 8'h96 -> done at T+9; pass=1; table_out=8'h96.
